// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx; req_valid->req_ready 1 cycle, ->tx_valid 2 cycles.
// tx_valid holds until tx_ready; per-requester byte counters exist only with UART_ARB_STATS_EN defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [8*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy,
    output logic [16*NUM_REQ-1:0] stat_bytes
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [7:0]    BURST_MAX = 8'(MAX_BURST);
    localparam logic [SW-1:0] STALL_MAX = SW'(HOLD_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_GAP,
        ST_HOLD
    } state_t;

    state_t             r_state;
    logic [IW-1:0]      r_last_grant;
    logic [IW-1:0]      r_gidx;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;
    logic               r_last_q;
    logic [7:0]         r_burst;
    logic [SW-1:0]      r_stall;
    logic               r_busy;

    logic [IW-1:0]      w_cand;
    logic [IW-1:0]      w_win_idx;
    logic               w_win_found;
    logic [NUM_REQ-1:0] w_win_oh;
    logic               w_cur_valid;
    logic               w_cur_last;
    logic [7:0]         w_cur_data;

    // Walk the requesters starting just after the previous owner; first valid one wins.
    always_comb begin
        w_cand      = r_last_grant;
        w_win_idx   = '0;
        w_win_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = (w_cand == LAST_IDX) ? '0 : w_cand + 1'b1;
            if (!w_win_found && req_valid[w_cand]) begin
                w_win_idx   = w_cand;
                w_win_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_win_oh    = '0;
        w_cur_valid = 1'b0;
        w_cur_last  = 1'b0;
        w_cur_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == IW'(i)) begin
                w_win_oh[i] = 1'b1;
            end
            if (r_gidx == IW'(i)) begin
                w_cur_valid = req_valid[i];
                w_cur_last  = req_last[i];
                w_cur_data  = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= LAST_IDX;
            r_gidx       <= '0;
            r_grant      <= '0;
            r_req_ready  <= '0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_last_q     <= 1'b0;
            r_burst      <= 8'h00;
            r_stall      <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_req_ready <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_win_found) begin
                        r_gidx      <= w_win_idx;
                        r_grant     <= w_win_oh;
                        r_busy      <= 1'b1;
                        r_burst     <= 8'h00;
                        r_req_ready <= w_win_oh;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_tx_data  <= w_cur_data;
                    r_last_q   <= w_cur_last;
                    r_burst    <= r_burst + 8'd1;
                    r_tx_valid <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    // Byte is committed: enable is ignored until the handshake.
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_last_q || (r_burst == BURST_MAX) || !enable) begin
                        r_last_grant <= r_gidx;
                        r_grant      <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (w_cur_valid) begin
                        r_req_ready <= r_grant;
                        r_state     <= ST_FETCH;
                    end else begin
                        r_stall <= '0;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_cur_valid) begin
                        r_req_ready <= r_grant;
                        r_state     <= ST_FETCH;
                    end else if (!enable || (r_stall == STALL_MAX)) begin
                        r_last_grant <= r_gidx;
                        r_grant      <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign grant     = r_grant;
    assign busy      = r_busy;

`ifdef UART_ARB_STATS_EN
    logic [15:0] r_stat [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat[i] <= 16'h0000;
            end
        end else if (r_tx_valid && tx_ready) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((r_gidx == IW'(i)) && (r_stat[i] != 16'hFFFF)) begin
                    r_stat[i] <= r_stat[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_bytes[16*g +: 16] = r_stat[g];
    end
`else
    assign stat_bytes = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=2, MAX_BURST=4, HOLD_TIMEOUT=16) with requester/sink models.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [1:0]  grant;
    logic        busy;
    logic [31:0] stat_bytes;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(2), .MAX_BURST(4), .HOLD_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant(grant), .busy(busy), .stat_bytes(stat_bytes)
    );

    int errors = 0;
    int checks = 0;

    // Requester byte queues as ring-less arrays: {last, data}, head/tail indices.
    logic [8:0] qmem [2][512];
    int qh [2];
    int qt [2];
    logic [9:0] txlog [$];
    int sink_dly;
    int sink_cnt;
    int rr_cnt [2];
    int viol = 0;

    typedef struct {
        int         req;
        logic [7:0] dat;
        logic       lst;
        logic [1:0] exp_g;
        logic [7:0] exp_d;
    } vec_t;
    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int r, input logic lst, input logic [7:0] d);
        qmem[r][qt[r]] = {lst, d};
        qt[r]++;
    endtask

    task automatic drive_reqs();
        logic [8:0] h;
        for (int i = 0; i < 2; i++) begin
            if (qt[i] > qh[i]) begin
                h = qmem[i][qh[i]];
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = h[7:0];
                req_last[i]       = h[8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic [1:0] rr;
        logic       hs;
        logic [9:0] ent;
        rr  = req_ready;
        hs  = tx_valid && tx_ready;
        ent = {grant, tx_data};
        if ((req_ready & ~grant) != 2'b00) viol++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rr[i]) begin
                rr_cnt[i]++;
                if (qt[i] > qh[i]) qh[i]++;
            end
        end
        if (hs) txlog.push_back(ent);
        if (tx_valid) begin
            tx_ready = (sink_cnt >= sink_dly);
            sink_cnt++;
        end else begin
            tx_ready = 1'b0;
            sink_cnt = 0;
        end
        drive_reqs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            qh[i] = 0;
            qt[i] = 0;
            rr_cnt[i] = 0;
        end
        txlog.delete();
        tx_ready = 1'b0;
        sink_cnt = 0;
        drive_reqs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (txlog.size() < n && c < budget) begin
            tick();
            c++;
        end
        check(name, 32'(txlog.size()), 32'(n));
    endtask

    int lo, hi, cnt, drop, exp_st, other;

    initial begin
        sink_dly = 1;
        sink_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            qh[i] = 0;
            qt[i] = 0;
            rr_cnt[i] = 0;
        end
        drive_reqs();

        // Round-robin: single-byte packets from both, reset leaves requester 0 first.
        vecs[0]  = '{0, 8'hA0, 1'b1, 2'b01, 8'hA0};
        vecs[1]  = '{0, 8'hA1, 1'b1, 2'b10, 8'hB0};
        vecs[2]  = '{1, 8'hB0, 1'b1, 2'b01, 8'hA1};
        vecs[3]  = '{1, 8'hB1, 1'b1, 2'b10, 8'hB1};
        // Burst limit 4: requester 0 streams 10 bytes with no last, requester 1 cuts in.
        vecs[4]  = '{0, 8'h00, 1'b0, 2'b01, 8'h00};
        vecs[5]  = '{0, 8'h01, 1'b0, 2'b01, 8'h01};
        vecs[6]  = '{0, 8'h02, 1'b0, 2'b01, 8'h02};
        vecs[7]  = '{0, 8'h03, 1'b0, 2'b01, 8'h03};
        vecs[8]  = '{0, 8'h04, 1'b0, 2'b10, 8'hB0};
        vecs[9]  = '{0, 8'h05, 1'b0, 2'b01, 8'h04};
        vecs[10] = '{0, 8'h06, 1'b0, 2'b01, 8'h05};
        vecs[11] = '{0, 8'h07, 1'b0, 2'b01, 8'h06};
        vecs[12] = '{0, 8'h08, 1'b0, 2'b01, 8'h07};
        vecs[13] = '{0, 8'h09, 1'b0, 2'b10, 8'hB1};
        vecs[14] = '{1, 8'hB0, 1'b1, 2'b01, 8'h08};
        vecs[15] = '{1, 8'hB1, 1'b1, 2'b01, 8'h09};

        // Reset values, sampled while reset is held.
        #3 rst = 1'b1;
        #3;
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_stat", stat_bytes, 0);

        // Single packet 41,42,43(last), tx_ready 5 cycles after tx_valid.
        do_reset();
        enable = 1'b1;
        sink_dly = 5;
        push(0, 1'b0, 8'h41);
        push(0, 1'b0, 8'h42);
        push(0, 1'b1, 8'h43);
        drive_reqs();
        tick();
        check("t1_ready_c1", 32'(req_ready), 32'h1);
        check("t1_grant_c1", 32'(grant), 32'h1);
        check("t1_txv_c1", 32'(tx_valid), 0);
        tick();
        check("t1_txv_c2", 32'(tx_valid), 1);
        check("t1_txd_c2", 32'(tx_data), 32'h41);
        wait_log(3, 200, "t1_count");
        check("t1_gap_grant", 32'(grant), 32'h1);
        check("t1_gap_txv", 32'(tx_valid), 0);
        tick();
        check("t1_release_grant", 32'(grant), 0);
        check("t1_release_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            if (i < txlog.size()) check($sformatf("t1_byte%0d", i), 32'(txlog[i]), 32'({2'b01, 8'(8'h41 + i)}));
        end
        check("t1_pops", 32'(rr_cnt[0]), 3);

        // Table-driven scenarios: round robin, then burst limit.
        for (int s = 0; s < 2; s++) begin
            lo = (s == 0) ? 0 : 4;
            hi = (s == 0) ? 4 : 16;
            do_reset();
            enable = 1'b1;
            sink_dly = 1;
            for (int i = lo; i < hi; i++) push(vecs[i].req, vecs[i].lst, vecs[i].dat);
            drive_reqs();
            wait_log(hi - lo, 800, $sformatf("scen%0d_count", s));
            for (int i = lo; i < hi; i++) begin
                if (i - lo < txlog.size())
                    check($sformatf("scen%0d_vec%0d", s, i), 32'(txlog[i - lo]), 32'({vecs[i].exp_g, vecs[i].exp_d}));
            end
        end
        cnt = 0;
        while (grant != 2'b00 && cnt < 40) begin
            tick();
            cnt++;
        end
        check("burst_final_release", 32'(grant), 0);
        check("no_foreign_ready", 32'(viol), 0);

        // Stall timeout: 16 HOLD cycles then release, requester 1 granted next cycle.
        do_reset();
        enable = 1'b1;
        sink_dly = 1;
        push(0, 1'b0, 8'h55);
        push(1, 1'b1, 8'h66);
        drive_reqs();
        wait_log(1, 50, "t3_first");
        check("t3_gap_grant", 32'(grant), 32'h1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (grant == 2'b01 && !tx_valid && req_ready == 2'b00) cnt++;
        end
        check("t3_hold_cycles", 32'(cnt), 16);
        tick();
        check("t3_idle_grant", 32'(grant), 0);
        tick();
        check("t3_next_grant", 32'(grant), 32'h2);
        check("t3_next_ready", 32'(req_ready), 32'h2);
        wait_log(2, 50, "t3_second");
        if (txlog.size() > 1) check("t3_second_byte", 32'(txlog[1]), 32'h266);

        // Enable drops during SEND: byte completes, grant releases, nothing more fetched.
        do_reset();
        enable = 1'b1;
        sink_dly = 4;
        push(0, 1'b0, 8'h11);
        push(0, 1'b0, 8'h12);
        drive_reqs();
        cnt = 0;
        while (!tx_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("t4_in_send", 32'(tx_valid), 1);
        enable = 1'b0;
        drop = 0;
        cnt = 0;
        while (txlog.size() < 1 && cnt < 50) begin
            if (!tx_valid) drop = 1;
            tick();
            cnt++;
        end
        check("t4_txv_held", 32'(drop), 0);
        check("t4_count", 32'(txlog.size()), 1);
        if (txlog.size() > 0) check("t4_byte", 32'(txlog[0]), 32'h111);
        tick();
        check("t4_release", 32'(grant), 0);
        for (int i = 0; i < 6; i++) tick();
        check("t4_no_fetch", 32'(rr_cnt[0]), 1);
        check("t4_pending", 32'(qt[0] - qh[0]), 1);

        // Reset asserted during SEND clears outputs asynchronously; fetched byte is not replayed.
        enable = 1'b1;
        sink_dly = 50;
        cnt = 0;
        while (!tx_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("t5_in_send", 32'(tx_valid), 1);
        rst = 1'b1;
        #1;
        check("t5_txv", 32'(tx_valid), 0);
        check("t5_grant", 32'(grant), 0);
        check("t5_ready", 32'(req_ready), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_txd", 32'(tx_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (tx_valid) cnt++;
        end
        check("t5_no_replay", 32'(cnt), 0);

        // 300 transfers from requester 1; counters exist only in the stats build.
        do_reset();
        enable = 1'b1;
        sink_dly = 0;
        for (int i = 0; i < 300; i++) push(1, 1'b1, 8'(i));
        drive_reqs();
        wait_log(300, 3000, "t6_count");
        other = 0;
        foreach (txlog[i]) if (txlog[i][9:8] != 2'b10) other++;
        check("t6_all_req1", 32'(other), 0);
`ifdef UART_ARB_STATS_EN
        exp_st = 300;
`else
        exp_st = 0;
`endif
        check("t6_stat1", 32'(stat_bytes[31:16]), 32'(exp_st));
        check("t6_stat0", 32'(stat_bytes[15:0]), 0);
        check("final_no_foreign_ready", 32'(viol), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
